// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in a final cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_ITER = 2'b10,
    ST_FIX  = 2'b11
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, opd_r, acc_hi_r, acc_lo_r, hi_r, lo_r;
  logic [CW-1:0]      cnt_r;
  logic               neg_q_r, neg_r_r, busy_r, done_r, div_zero_r;

  logic               is_div_s, is_signed_s, a_neg_s, b_neg_s, b_zero_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, hi_res_s, lo_res_s;
  logic [WIDTH:0]     mul_sum_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s;

  assign is_div_s    = op_r[1];
  assign is_signed_s = ~op_r[0];
  assign a_neg_s     = is_signed_s & a_r[WIDTH-1];
  assign b_neg_s     = is_signed_s & b_r[WIDTH-1];
  assign a_mag_s     = a_neg_s ? -a_r : a_r;
  assign b_mag_s     = b_neg_s ? -b_r : b_r;
  assign b_zero_s    = (b_r == {WIDTH{1'b0}});
  assign mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
  assign div_diff_s  = {acc_hi_r, acc_lo_r[WIDTH-1]} - {1'b0, opd_r};
  assign prod_s      = {acc_hi_r, acc_lo_r};

  // Next-state logic for the operation sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_PREP;
        else       state_s = ST_IDLE;
      end
      ST_PREP: state_s = ST_ITER;
      ST_ITER: begin
        if (cnt_r == {CW{1'b0}}) state_s = ST_FIX;
        else                     state_s = ST_ITER;
      end
      ST_FIX:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Sign-corrected result; divide by zero returns all-ones quotient and the raw dividend.
  always_comb begin
    hi_res_s = {WIDTH{1'b0}};
    lo_res_s = {WIDTH{1'b0}};
    if (!is_div_s) begin
      if (neg_q_r) {hi_res_s, lo_res_s} = -prod_s;
      else         {hi_res_s, lo_res_s} = prod_s;
    end else if (b_zero_s) begin
      hi_res_s = a_r;
      lo_res_s = {WIDTH{1'b1}};
    end else begin
      hi_res_s = neg_r_r ? -acc_hi_r : acc_hi_r;
      lo_res_s = neg_q_r ? -acc_lo_r : acc_lo_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_r       <= 2'b00;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      opd_r      <= {WIDTH{1'b0}};
      acc_hi_r   <= {WIDTH{1'b0}};
      acc_lo_r   <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r       <= op;
            a_r        <= src_a;
            b_r        <= src_b;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            if (hi_we) hi_r <= wdata;
            if (lo_we) lo_r <= wdata;
          end
        end
        ST_PREP: begin
          acc_hi_r <= {WIDTH{1'b0}};
          neg_q_r  <= a_neg_s ^ b_neg_s;
          neg_r_r  <= a_neg_s & is_div_s;
          cnt_r    <= CW'(ITER - 1);
          if (is_div_s) begin
            opd_r    <= b_mag_s;
            acc_lo_r <= a_mag_s;
          end else begin
            opd_r    <= a_mag_s;
            acc_lo_r <= b_mag_s;
          end
        end
        ST_ITER: begin
          cnt_r <= cnt_r - CW'(1);
          if (!is_div_s) begin
            acc_hi_r <= mul_sum_s[WIDTH:1];
            acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
          end else begin
            if (!div_diff_s[WIDTH]) acc_hi_r <= div_diff_s[WIDTH-1:0];
            else                    acc_hi_r <= {acc_hi_r[WIDTH-2:0], acc_lo_r[WIDTH-1]};
            acc_lo_r <= {acc_lo_r[WIDTH-2:0], ~div_diff_s[WIDTH]};
          end
        end
        ST_FIX: begin
          hi_r       <= hi_res_s;
          lo_r       <= lo_res_s;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          div_zero_r <= is_div_s & b_zero_s;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic, latency, divide-by-zero,
// hazards on start/MTHI while busy, mid-operation reset and back-to-back starts.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'h0, src_b = 32'h0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail = 0;

  mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait (bounded) for done; returns edges to done and busy samples.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h0BAD_F00D;
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b expected 0", div_zero); end
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h_%h expected 0", hi, lo); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_multu_small();
    int lat, bc;
    run_op(2'b01, 32'h5, 32'h6, lat, bc);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    n_checks++; if (bc !== 34) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 34", bc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
    n_checks++; if ({hi, lo} !== 64'h0000_0000_0000_001E) begin n_fail++; $display("FAIL multu_result: got %h_%h expected 00000000_0000001e", hi, lo); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", done); end
  endtask

  // Table of arithmetic vectors with hand-computed HI/LO.
  task automatic test_arith();
    logic [1:0]  v_op [6];
    logic [31:0] v_a [6], v_b [6], v_hi [6], v_lo [6];
    int lat, bc;
    v_op[0] = 2'b00; v_a[0] = 32'hFFFF_FFFE; v_b[0] = 32'h3;         v_hi[0] = 32'hFFFF_FFFF; v_lo[0] = 32'hFFFF_FFFA;
    v_op[1] = 2'b01; v_a[1] = 32'hFFFF_FFFF; v_b[1] = 32'hFFFF_FFFF; v_hi[1] = 32'hFFFF_FFFE; v_lo[1] = 32'h0000_0001;
    v_op[2] = 2'b10; v_a[2] = 32'hFFFF_FFF9; v_b[2] = 32'h2;         v_hi[2] = 32'hFFFF_FFFF; v_lo[2] = 32'hFFFF_FFFD;
    v_op[3] = 2'b10; v_a[3] = 32'h8000_0000; v_b[3] = 32'hFFFF_FFFF; v_hi[3] = 32'h0;         v_lo[3] = 32'h8000_0000;
    v_op[4] = 2'b10; v_a[4] = 32'h7;         v_b[4] = 32'hFFFF_FFFE; v_hi[4] = 32'h1;         v_lo[4] = 32'hFFFF_FFFD;
    v_op[5] = 2'b11; v_a[5] = 32'hFFFF_FFFF; v_b[5] = 32'h10;        v_hi[5] = 32'hF;         v_lo[5] = 32'h0FFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], lat, bc);
      n_checks++;
      if (lat !== 34 || hi !== v_hi[i] || lo !== v_lo[i]) begin
        n_fail++;
        $display("FAIL arith_vec%0d: got lat=%0d hi=%h lo=%h expected lat=34 hi=%h lo=%h",
                 i, lat, hi, lo, v_hi[i], v_lo[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_op(2'b11, 32'h1234_5678, 32'h0, lat, bc);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 34", lat); end
    n_checks++; if ({hi, lo} !== 64'h1234_5678_FFFF_FFFF) begin n_fail++; $display("FAIL divzero_result: got %h_%h expected 12345678_ffffffff", hi, lo); end
    n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL divzero_flag: got %b expected 1", div_zero); end
    tick();
    n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL divzero_sticky: got %b expected 1", div_zero); end
    start = 1'b1; op = 2'b01; src_a = 32'h3; src_b = 32'h4;
    tick();
    start = 1'b0;
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL divzero_clear: got %b expected 0", div_zero); end
    for (int i = 0; i < 60 && done !== 1'b1; i++) tick();
    n_checks++; if ({hi, lo} !== 64'hC) begin n_fail++; $display("FAIL after_divzero_result: got %h_%h expected 0_c", hi, lo); end
  endtask

  task automatic test_hazard();
    int lat;
    logic stable;
    start = 1'b1; op = 2'b01; src_a = 32'h7; src_b = 32'h8;
    tick();
    start = 1'b0;
    lat = 0; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); lat++; end
    start = 1'b1; op = 2'b10; src_a = 32'h100; src_b = 32'h3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    tick(); lat++;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    while (done !== 1'b1 && lat < 60) begin
      if (hi !== 32'h0 || lo !== 32'hC) stable = 1'b0;
      tick();
      lat++;
    end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hazard_hilo_stable: got %b expected 1", stable); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL hazard_latency: got %0d expected 34", lat); end
    n_checks++; if ({hi, lo} !== 64'h38) begin n_fail++; $display("FAIL hazard_result: got %h_%h expected 0_38", hi, lo); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hazard_no_relaunch: got busy=%b expected 0", busy); end
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    hi_we = 1'b0;
    n_checks++; if ({hi, lo} !== 64'hCAFE_F00D_0000_0038) begin n_fail++; $display("FAIL mthi: got %h_%h expected cafef00d_00000038", hi, lo); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1357_9BDF;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    n_checks++; if ({hi, lo} !== 64'h1357_9BDF_1357_9BDF) begin n_fail++; $display("FAIL mthi_mtlo_both: got %h_%h expected 13579bdf_13579bdf", hi, lo); end
    start = 1'b1; op = 2'b01; src_a = 32'h2; src_b = 32'h2; lo_we = 1'b1; wdata = 32'hFFFF_0000;
    tick();
    start = 1'b0; lo_we = 1'b0;
    n_checks++; if (lo !== 32'h1357_9BDF) begin n_fail++; $display("FAIL mtlo_with_start: got %h expected 13579bdf", lo); end
    for (int i = 0; i < 60 && done !== 1'b1; i++) tick();
    n_checks++; if ({hi, lo} !== 64'h4) begin n_fail++; $display("FAIL mtlo_with_start_result: got %h_%h expected 0_4", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(2'b00, 32'h0000_0010, 32'hFFFF_FFF0, lat, bc);
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FF00) begin n_fail++; $display("FAIL b2b_first: got %h_%h expected ffffffff_ffffff00", hi, lo); end
    run_op(2'b11, 32'd100, 32'd7, lat, bc);
    n_checks++; if (lat !== 34 || bc !== 34) begin n_fail++; $display("FAIL b2b_timing: got lat=%0d busy=%0d expected 34/34", lat, bc); end
    n_checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL b2b_second: got %h_%h expected 00000002_0000000e", hi, lo); end
  endtask

  task automatic test_reset_mid_op();
    logic done_seen;
    start = 1'b1; op = 2'b01; src_a = 32'h9; src_b = 32'h9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || {hi, lo} !== 64'h0) begin n_fail++; $display("FAIL mid_reset_state: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo); end
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
      tick();
    end
    n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_aborted: got activity=%b expected 0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_multu_small();
    test_arith();
    test_div_zero();
    test_hazard();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
